// File: rtl/change_dispenser.sv
// change_dispenser: pays a change amount out as quarters, dimes and nickels over a
// coin_req/hopper_ack handshake, tracking per-denomination inventory with saturating refills.
module change_dispenser #(
    parameter int CNT_W       = 8,
    parameter int Q_INIT      = 20,
    parameter int D_INIT      = 20,
    parameter int N_INIT      = 20,
    parameter int MAX_CHANGE  = 95,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             change_valid,
    input  logic [6:0]       change_amt,
    output logic             change_ready,
    output logic             coin_req,
    output logic [1:0]       coin_type,
    input  logic             hopper_ack,
    input  logic             refill_valid,
    input  logic [1:0]       refill_type,
    input  logic [CNT_W-1:0] refill_count,
    output logic [CNT_W-1:0] q_cnt,
    output logic [CNT_W-1:0] d_cnt,
    output logic [CNT_W-1:0] n_cnt,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [6:0]       short_amt
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CHECK, SELECT, WAIT_ACK, DONE, ERR} state_t;

    state_t         state, state_nx;
    logic [4:0]     rem, rem_nx;
    logic [TW-1:0]  tmo, tmo_nx;
    logic [1:0]     type_nx, code_nx;
    logic [6:0]     short_nx, rem_cents;
    logic [4:0]     coin_val;
    logic           bad_amt, ack_ok;

    function automatic logic [CNT_W-1:0] sat_init(input int v);
        return (v > (2 ** CNT_W - 1)) ? '1 : CNT_W'(v);
    endfunction

    // Refill and ack decrement on the same edge combine before saturation.
    function automatic logic [CNT_W-1:0] upd(input logic [CNT_W-1:0] c, input logic add,
                                             input logic [CNT_W-1:0] amt, input logic sub);
        logic [CNT_W:0] s;
        s = {1'b0, c} + (add ? {1'b0, amt} : '0) - {{CNT_W{1'b0}}, sub};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign change_ready = state == IDLE;
    assign coin_req     = state == WAIT_ACK;
    assign done         = state == DONE;
    assign err          = state == ERR;
    assign ack_ok       = coin_req && hopper_ack;
    assign bad_amt      = change_amt > 7'(MAX_CHANGE) || change_amt % 7'd5 != 7'd0;
    assign rem_cents    = 7'({2'b00, rem} * 7'd5);
    assign coin_val     = coin_type == 2'b10 ? 5'd5 : coin_type == 2'b01 ? 5'd2 : 5'd1;

    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        tmo_nx   = tmo;
        type_nx  = coin_type;
        code_nx  = err_code;
        short_nx = short_amt;
        case (state)
            IDLE: if (change_valid) begin
                if (bad_amt) begin
                    state_nx = ERR;
                    code_nx  = 2'b01;
                    short_nx = change_amt;
                end else begin
                    state_nx = CHECK;
                    rem_nx   = 5'(change_amt / 7'd5);
                    code_nx  = 2'b00;
                    short_nx = 7'd0;
                end
            end
            CHECK: state_nx = rem == 5'd0 ? DONE : SELECT;
            SELECT: begin
                tmo_nx   = '0;
                state_nx = WAIT_ACK;
                if (rem >= 5'd5 && q_cnt != '0)      type_nx = 2'b10;
                else if (rem >= 5'd2 && d_cnt != '0) type_nx = 2'b01;
                else if (n_cnt != '0)                type_nx = 2'b00;
                else begin
                    state_nx = ERR;
                    code_nx  = 2'b10;
                    short_nx = rem_cents;
                end
            end
            WAIT_ACK: if (hopper_ack) begin
                rem_nx   = rem - coin_val;
                state_nx = CHECK;
            end else if (tmo == TW'(ACK_TIMEOUT - 1)) begin
                state_nx = ERR;
                code_nx  = 2'b11;
                short_nx = rem_cents;
            end else begin
                tmo_nx = tmo + 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rem       <= '0;
            tmo       <= '0;
            coin_type <= 2'b00;
            err_code  <= 2'b00;
            short_amt <= 7'd0;
            q_cnt     <= sat_init(Q_INIT);
            d_cnt     <= sat_init(D_INIT);
            n_cnt     <= sat_init(N_INIT);
        end else begin
            state     <= state_nx;
            rem       <= rem_nx;
            tmo       <= tmo_nx;
            coin_type <= type_nx;
            err_code  <= code_nx;
            short_amt <= short_nx;
            q_cnt     <= upd(q_cnt, refill_valid && refill_type == 2'b10, refill_count,
                             ack_ok && coin_type == 2'b10);
            d_cnt     <= upd(d_cnt, refill_valid && refill_type == 2'b01, refill_count,
                             ack_ok && coin_type == 2'b01);
            n_cnt     <= upd(n_cnt, refill_valid && refill_type == 2'b00, refill_count,
                             ack_ok && coin_type == 2'b00);
        end
    end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed checks of change_dispenser payout, errors, refill and reset.
module tb_change_dispenser;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       change_valid;
    logic [6:0] change_amt;
    logic       change_ready, coin_req, hopper_ack, refill_valid, done, err;
    logic [1:0] coin_type, refill_type, err_code;
    logic [7:0] refill_count, q_cnt, d_cnt, n_cnt;
    logic [6:0] short_amt;
    logic       auto_ack, man_ack, cr_seen;
    logic [1:0] log_q[$];
    int         ncmp = 0, nfail = 0, k, crh;

    change_dispenser #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .change_valid(change_valid), .change_amt(change_amt),
        .change_ready(change_ready), .coin_req(coin_req), .coin_type(coin_type),
        .hopper_ack(hopper_ack), .refill_valid(refill_valid), .refill_type(refill_type),
        .refill_count(refill_count), .q_cnt(q_cnt), .d_cnt(d_cnt), .n_cnt(n_cnt),
        .done(done), .err(err), .err_code(err_code), .short_amt(short_amt)
    );

    always #5 clk = ~clk;

    // Hopper either acks on the first request cycle or is driven by hand.
    assign hopper_ack = auto_ack ? coin_req : man_ack;

    always @(negedge clk) begin
        if (coin_req) cr_seen = 1'b1;
        if (coin_req && hopper_ack) log_q.push_back(coin_type);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [6:0] a);
        @(negedge clk);
        change_valid = 1'b1;
        change_amt   = a;
        @(negedge clk);
        change_valid = 1'b0;
    endtask

    task automatic wait_end(output int n);
        n = 1;
        while (!(done || err) && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (!coin_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", coin_req, 1);
    endtask

    initial begin
        rst_n = 1'b0; change_valid = 1'b0; change_amt = 7'd0; refill_valid = 1'b0;
        refill_type = 2'b00; refill_count = 8'd0; auto_ack = 1'b1; man_ack = 1'b0; cr_seen = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", change_ready, 1);
        chk("rst_req", coin_req, 0);
        chk("rst_type", coin_type, 0);
        chk("rst_done_err", {done, err}, 0);
        chk("rst_code_short", {err_code, short_amt}, 0);
        chk("rst_cnts", {q_cnt, d_cnt, n_cnt}, {8'd20, 8'd20, 8'd20});
        rst_n = 1'b1;

        log_q.delete();
        send(65); wait_end(k);
        chk("c65_done", done, 1);
        chk("c65_code", err_code, 0);
        chk("c65_ncoins", log_q.size(), 4);
        chk("c65_coins", {log_q[0], log_q[1], log_q[2], log_q[3]}, {2'b10, 2'b10, 2'b01, 2'b00});
        chk("c65_cnts", {q_cnt, d_cnt, n_cnt}, {8'd18, 8'd19, 8'd19});

        cr_seen = 1'b0;
        send(0); wait_end(k);
        chk("zero_lat", k, 2);
        chk("zero_done", done, 1);
        chk("zero_noreq", cr_seen, 0);

        for (int i = 0; i < 17; i++) begin send(25); wait_end(k); end
        for (int i = 0; i < 16; i++) begin send(10); wait_end(k); end
        for (int i = 0; i < 19; i++) begin send(5);  wait_end(k); end
        chk("drain_cnts", {q_cnt, d_cnt, n_cnt}, {8'd1, 8'd3, 8'd0});

        log_q.delete();
        send(30); wait_end(k);
        chk("short_err", err, 1);
        chk("short_code", err_code, 2);
        chk("short_amt", short_amt, 5);
        chk("short_coins", {log_q.size(), log_q[0]}, {32'd1, 2'b10});
        chk("short_cnts", {q_cnt, d_cnt, n_cnt}, {8'd0, 8'd3, 8'd0});

        @(negedge clk);
        refill_valid = 1'b1; refill_type = 2'b00; refill_count = 8'd254;
        @(negedge clk);
        refill_valid = 1'b0;
        chk("refill_n", n_cnt, 254);

        auto_ack = 1'b0;
        send(5); wait_req();
        man_ack = 1'b1; refill_valid = 1'b1; refill_type = 2'b00; refill_count = 8'd5;
        @(negedge clk);
        man_ack = 1'b0; refill_valid = 1'b0;
        chk("sat_n", n_cnt, 255);
        wait_end(k);
        chk("sat_done", done, 1);

        send(10);
        k = 1; crh = 0;
        while (!err && k < 100) begin
            if (coin_req) crh++;
            @(negedge clk);
            k++;
        end
        chk("tmo_err", err, 1);
        chk("tmo_reqcyc", crh, 4);
        chk("tmo_code_short", {err_code, short_amt}, {2'b11, 7'd10});
        chk("tmo_d", d_cnt, 3);

        send(97); wait_end(k);
        chk("bad97_lat", k, 1);
        chk("bad97", {err, err_code, short_amt}, {1'b1, 2'b01, 7'd97});
        send(37); wait_end(k);
        chk("bad37", {err, err_code, short_amt}, {1'b1, 2'b01, 7'd37});

        send(10); wait_req();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", coin_req, 0);
        chk("mid_rst_cnts", {q_cnt, d_cnt, n_cnt}, {8'd20, 8'd20, 8'd20});
        chk("mid_rst_ready", change_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        auto_ack = 1'b1;
        send(10); wait_end(k);
        chk("post_rst", {done, d_cnt}, {1'b1, 8'd19});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
